// File: rtl/stage_sequencer_pkg.sv
// -----------------------------------------------------------------------------
// stage_sequencer_pkg
// Shared definitions for the instruction stage sequencer:
//   - state_e      : 3-bit FSM state encoding S_PCF..S_HALT
//   - WORD_DEF     : default counter width
//   - NUM_WB_DEF   : default number of write-back channels
//   - WB_REG/WB_MEM/WB_FLAG : customary channel indices
// -----------------------------------------------------------------------------
package stage_sequencer_pkg;

   typedef enum logic [2:0] {
      S_PCF   = 3'd0,
      S_FETCH = 3'd1,
      S_REG   = 3'd2,
      S_EXEC  = 3'd3,
      S_WBI   = 3'd4,
      S_WBW   = 3'd5,
      S_PCWB  = 3'd6,
      S_HALT  = 3'd7
   } state_e;

   localparam int WORD_DEF   = 16;
   localparam int NUM_WB_DEF = 3;

   localparam int WB_REG  = 0;
   localparam int WB_MEM  = 1;
   localparam int WB_FLAG = 2;

   function automatic logic is_busy(input state_e s);
      return (s != S_PCF) && (s != S_HALT);
   endfunction

endpackage

// File: rtl/stage_sequencer_wb_tracker.sv
// -----------------------------------------------------------------------------
// stage_sequencer_wb_tracker  (the wb_tracker of the stage sequencer)
// Holds the latched write-back request set, generates the one-cycle wb_tr
// strobes, tracks which channels still await an acknowledge, and reports
// when every requested channel is done.
// Optional watchdog, enabled by defining SEQ_WB_TIMEOUT_EN: counts cycles
// spent waiting in S_WBW and flags wd_expire / sticky wb_timeout.
//
// Ports:
//   clk, rst     : clock, synchronous active-high reset
//   state        : current sequencer state
//   wb_req       : per-channel requests, latched while in S_EXEC
//   wb_ack       : per-channel acknowledges
//   wb_tr        : strobes, equal to the latched request in S_WBI
//   wb_pending   : channels still awaiting acknowledge
//   wb_done      : no channel remains once this cycle's acks are applied
//   wd_expire    : watchdog fires this cycle (0 when feature disabled)
//   wb_timeout   : sticky watchdog flag (0 when feature disabled)
// -----------------------------------------------------------------------------
module stage_sequencer_wb_tracker
   import stage_sequencer_pkg::*;
#(
   parameter int NUM_WB = NUM_WB_DEF
`ifdef SEQ_WB_TIMEOUT_EN
   , parameter int WB_TIMEOUT = 15
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  state_e            state,
   input  logic [NUM_WB-1:0] wb_req,
   input  logic [NUM_WB-1:0] wb_ack,
   output logic [NUM_WB-1:0] wb_tr,
   output logic [NUM_WB-1:0] wb_pending,
   output logic              wb_done,
   output logic              wd_expire,
   output logic              wb_timeout
);

   logic [NUM_WB-1:0] req_q;
   logic [NUM_WB-1:0] rem;

   // In the strobe cycle the latched request is the outstanding set, so an
   // ack arriving together with its strobe already counts.
   assign rem     = ((state == S_WBI) ? req_q : wb_pending) & ~wb_ack;
   assign wb_done = (rem == '0);
   assign wb_tr   = (state == S_WBI) ? req_q : '0;

`ifdef SEQ_WB_TIMEOUT_EN
   localparam int WDW = (WB_TIMEOUT > 1) ? $clog2(WB_TIMEOUT) : 1;

   logic [WDW-1:0] wd_cnt;

   // wd_cnt is 0 in the first S_WBW cycle, so expiry lands after exactly
   // WB_TIMEOUT waiting cycles. A final ack in that cycle still wins.
   assign wd_expire = (state == S_WBW) && !wb_done &&
                      (wd_cnt == WDW'(WB_TIMEOUT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         wd_cnt     <= '0;
         wb_timeout <= 1'b0;
      end else begin
         if (state == S_WBI)
            wd_cnt <= '0;
         else if (state == S_WBW)
            wd_cnt <= wd_cnt + 1'b1;
         if (wd_expire)
            wb_timeout <= 1'b1;
      end
   end
`else
   assign wd_expire  = 1'b0;
   assign wb_timeout = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q      <= '0;
         wb_pending <= '0;
      end else begin
         if (state == S_EXEC)
            req_q <= wb_req;
         if ((state == S_WBI) || (state == S_WBW))
            wb_pending <= wd_expire ? '0 : rem;
      end
   end

endmodule

// File: rtl/stage_sequencer.sv
// -----------------------------------------------------------------------------
// stage_sequencer
// Per-instruction stage controller: PC fetch -> instruction fetch ->
// register read -> decode/execute -> write-back -> PC write-back, with
// run/halt control, cycle and retired-instruction counters and NUM_WB
// independent write-back channels (request/acknowledge).
// Optional write-back watchdog: define SEQ_WB_TIMEOUT_EN (adds WB_TIMEOUT).
//
//   state  | meaning
//   S_PCF  | PC fetch; waits here while run=0
//   S_FETCH| instruction fetch
//   S_REG  | register read
//   S_EXEC | decode/execute; write-back requests latched
//   S_WBI  | write-back strobe cycle
//   S_WBW  | waiting for remaining acknowledges
//   S_PCWB | PC write-back; instruction retires; halt_req sampled
//   S_HALT | stopped until reset
//
// Ports:
//   clk, rst      : clock, synchronous active-high reset
//   run           : start/continue, sampled in S_PCF
//   halt_req      : stop after this instruction, sampled in S_PCWB
//   wb_req/wb_ack : per-channel write-back request / done
//   pc_fetch, fetch_tr, reg_tr, dne_tr, pc_wb_tr : stage indicators
//   wb_tr         : per-channel write-back strobes
//   busy, halted  : status
//   wb_pending    : channels awaiting acknowledge
//   cycles        : free-running cycle count (wraps)
//   instr_count   : retired instructions (wraps)
//   wb_timeout    : sticky watchdog flag (0 unless SEQ_WB_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module stage_sequencer
   import stage_sequencer_pkg::*;
#(
   parameter int WORD   = WORD_DEF,
   parameter int NUM_WB = NUM_WB_DEF
`ifdef SEQ_WB_TIMEOUT_EN
   , parameter int WB_TIMEOUT = 15
`endif
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              halt_req,
   input  logic [NUM_WB-1:0] wb_req,
   input  logic [NUM_WB-1:0] wb_ack,
   output logic              pc_fetch,
   output logic              fetch_tr,
   output logic              reg_tr,
   output logic              dne_tr,
   output logic [NUM_WB-1:0] wb_tr,
   output logic              pc_wb_tr,
   output logic              busy,
   output logic              halted,
   output logic [NUM_WB-1:0] wb_pending,
   output logic [WORD-1:0]   cycles,
   output logic [WORD-1:0]   instr_count,
   output logic              wb_timeout
);

   state_e state;
   logic   wb_done;
   logic   wd_expire;

   stage_sequencer_wb_tracker #(
      .NUM_WB     (NUM_WB)
`ifdef SEQ_WB_TIMEOUT_EN
      , .WB_TIMEOUT (WB_TIMEOUT)
`endif
   ) u_wb_tracker (
      .clk        (clk),
      .rst        (rst),
      .state      (state),
      .wb_req     (wb_req),
      .wb_ack     (wb_ack),
      .wb_tr      (wb_tr),
      .wb_pending (wb_pending),
      .wb_done    (wb_done),
      .wd_expire  (wd_expire),
      .wb_timeout (wb_timeout)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= S_PCF;
         cycles      <= '0;
         instr_count <= '0;
      end else begin
         cycles <= cycles + 1'b1;
         case (state)
            S_PCF:   if (run) state <= S_FETCH;
            S_FETCH: state <= S_REG;
            S_REG:   state <= S_EXEC;
            S_EXEC:  state <= S_WBI;
            S_WBI:   state <= wb_done ? S_PCWB : S_WBW;
            S_WBW: begin
               if (wd_expire)
                  state <= S_HALT;
               else if (wb_done)
                  state <= S_PCWB;
            end
            S_PCWB: begin
               instr_count <= instr_count + 1'b1;
               state       <= halt_req ? S_HALT : S_PCF;
            end
            S_HALT:  state <= S_HALT;
            default: state <= S_PCF;
         endcase
      end
   end

   assign pc_fetch = (state == S_PCF);
   assign fetch_tr = (state == S_FETCH);
   assign reg_tr   = (state == S_REG);
   assign dne_tr   = (state == S_EXEC);
   assign pc_wb_tr = (state == S_PCWB);
   assign halted   = (state == S_HALT);
   assign busy     = is_busy(state);

endmodule

// File: tb/tb_stage_sequencer.sv
// -----------------------------------------------------------------------------
// tb_stage_sequencer
// Scoreboard bench for stage_sequencer: each instruction pushes its expected
// length and retired count when it is launched; the record is popped and
// compared when the DUT raises pc_wb_tr. Counters are narrowed to 6 bits so
// wrap-around is reached quickly.
// -----------------------------------------------------------------------------
module tb_stage_sequencer;

   localparam int W   = 6;
   localparam int NWB = 3;

   logic           clk = 1'b0;
   logic           rst = 1'b1;
   logic           run = 1'b0;
   logic           halt_req = 1'b0;
   logic [NWB-1:0] wb_req = '0;
   logic [NWB-1:0] wb_ack = '0;

   logic           pc_fetch, fetch_tr, reg_tr, dne_tr, pc_wb_tr;
   logic           busy, halted, wb_timeout;
   logic [NWB-1:0] wb_tr, wb_pending;
   logic [W-1:0]   cycles, instr_count;

`ifdef SEQ_WB_TIMEOUT_EN
   stage_sequencer #(.WORD(W), .NUM_WB(NWB), .WB_TIMEOUT(4)) dut (
`else
   stage_sequencer #(.WORD(W), .NUM_WB(NWB)) dut (
`endif
      .clk         (clk),
      .rst         (rst),
      .run         (run),
      .halt_req    (halt_req),
      .wb_req      (wb_req),
      .wb_ack      (wb_ack),
      .pc_fetch    (pc_fetch),
      .fetch_tr    (fetch_tr),
      .reg_tr      (reg_tr),
      .dne_tr      (dne_tr),
      .wb_tr       (wb_tr),
      .pc_wb_tr    (pc_wb_tr),
      .busy        (busy),
      .halted      (halted),
      .wb_pending  (wb_pending),
      .cycles      (cycles),
      .instr_count (instr_count),
      .wb_timeout  (wb_timeout)
   );

   always #5 clk = ~clk;

   localparam logic [NWB-1:0] M_REG  = NWB'(1 << stage_sequencer_pkg::WB_REG);
   localparam logic [NWB-1:0] M_MEM  = NWB'(1 << stage_sequencer_pkg::WB_MEM);
   localparam logic [NWB-1:0] M_FLAG = NWB'(1 << stage_sequencer_pkg::WB_FLAG);

   typedef struct {
      logic [NWB-1:0] req;
      int             len;
      logic [W-1:0]   ic;
   } exp_t;

   exp_t         sb[$];
   int           n_tests = 0;
   int           n_fail  = 0;
   logic [W-1:0] exp_ic  = '0;
   logic [W-1:0] exp_cyc = '0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Advance one clock; outputs are sampled 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      exp_cyc = rst ? '0 : exp_cyc + 1'b1;
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; run = 1'b0; halt_req = 1'b0; wb_req = '0; wb_ack = '0;
      step();
      step();
      exp_ic = '0;
      chk("rst_pc_fetch",   32'(pc_fetch),    32'd1);
      chk("rst_fetch_tr",   32'(fetch_tr),    32'd0);
      chk("rst_reg_tr",     32'(reg_tr),      32'd0);
      chk("rst_dne_tr",     32'(dne_tr),      32'd0);
      chk("rst_wb_tr",      32'(wb_tr),       32'd0);
      chk("rst_pc_wb_tr",   32'(pc_wb_tr),    32'd0);
      chk("rst_halted",     32'(halted),      32'd0);
      chk("rst_busy",       32'(busy),        32'd0);
      chk("rst_wb_pending", 32'(wb_pending),  32'd0);
      chk("rst_cycles",     32'(cycles),      32'd0);
      chk("rst_instr",      32'(instr_count), 32'd0);
      chk("rst_timeout",    32'(wb_timeout),  32'd0);
      rst = 1'b0;
   endtask

   // One instruction starting from an S_PCF cycle. d0..d2: cycles after the
   // strobe at which each channel acks (-1 = never). noise: acks driven on
   // non-requested channels while waiting.
   task automatic do_instr(input logic [NWB-1:0] req, input int d0, input int d1,
                           input int d2, input logic [NWB-1:0] noise, input logic halt);
      int   d[NWB];
      int   maxd;
      int   strobes;
      bit   done;
      exp_t e;
      d[0] = d0; d[1] = d1; d[2] = d2;
      maxd = 0;
      for (int c = 0; c < NWB; c++)
         if (req[c] && d[c] > maxd) maxd = d[c];
      e.req = req;
      e.len = 6 + maxd;
      e.ic  = exp_ic + 1'b1;
      sb.push_back(e);
      run = 1'b1; wb_req = req; halt_req = halt;
      strobes = 0;
      done = 1'b0;
      for (int t = 0; t < 64 && !done; t++) begin
         logic [NWB-1:0] ack;
         logic [NWB-1:0] ep;
         ack = '0;
         ep  = '0;
         for (int c = 0; c < NWB; c++) begin
            if (req[c] && d[c] >= 0 && t == 4 + d[c]) ack[c] = 1'b1;
            if (req[c] && t >= 5 && (d[c] < 0 || 4 + d[c] >= t)) ep[c] = 1'b1;
         end
         if (t >= 4 && t < 4 + maxd) ack = ack | (noise & ~req);
         wb_ack = ack;
         chk("busy", 32'(busy), 32'(t != 0));
         if (t < 4) begin
            chk("pc_fetch", 32'(pc_fetch), 32'(t == 0));
            chk("fetch_tr", 32'(fetch_tr), 32'(t == 1));
            chk("reg_tr",   32'(reg_tr),   32'(t == 2));
            chk("dne_tr",   32'(dne_tr),   32'(t == 3));
         end
         if (t == 4) chk("wb_tr", 32'(wb_tr), 32'(req));
         if (wb_tr != '0) strobes++;
         if (t >= 5) chk("wb_pending", 32'(wb_pending), 32'(ep));
         if (pc_wb_tr) begin
            e = sb.pop_front();
            chk("instr_len", 32'(t + 1), 32'(e.len));
            exp_ic = e.ic;
            done = 1'b1;
         end
         step();
      end
      wb_ack = '0;
      chk("pc_wb_seen", 32'(done), 32'd1);
      chk("strobe_count", 32'(strobes), 32'(req != '0));
      chk("instr_count", 32'(instr_count), 32'(exp_ic));
      chk("cycles", 32'(cycles), 32'(exp_cyc));
   endtask

   initial begin
      // back-to-back minimum instructions
      do_reset();
      repeat (3) do_instr('0, -1, -1, -1, '0, 1'b0);
      chk("cycles_at_18", 32'(cycles), 32'd18);
      chk("instr_at_18",  32'(instr_count), 32'd3);

      // reg acks with the strobe, mem three cycles later
      do_instr(M_REG | M_MEM, 0, 3, -1, '0, 1'b0);
      // reg+flag requested, stray acks on mem, then both ack together
      do_instr(M_REG | M_FLAG, 3, -1, 3, M_MEM, 1'b0);
      // simultaneous strobe-cycle acks on all channels
      do_instr(M_REG | M_MEM | M_FLAG, 0, 0, 0, '0, 1'b0);

      // run long enough for both counters to wrap
      repeat (60) do_instr('0, -1, -1, -1, '0, 1'b0);
      chk("instr_wrap", 32'(instr_count), 32'd2);

      // halt after the second instruction
      do_reset();
      do_instr('0, -1, -1, -1, '0, 1'b0);
      do_instr(M_MEM, 1, 1, 1, '0, 1'b1);
      chk("halt_halted", 32'(halted), 32'd1);
      chk("halt_busy",   32'(busy),   32'd0);
      chk("halt_instr",  32'(instr_count), 32'd2);
      halt_req = 1'b0;
      repeat (5) step();
      chk("halt_cycles_run", 32'(cycles), 32'(exp_cyc));
      chk("halt_instr_frozen", 32'(instr_count), 32'd2);
      chk("halt_sticky", 32'(halted), 32'd1);
      chk("halt_pc_fetch", 32'(pc_fetch), 32'd0);
      do_reset();

      // reset while waiting on a flag write-back
      run = 1'b1; wb_req = M_FLAG; wb_ack = '0;
      repeat (6) step();
      chk("abort_pending_before", 32'(wb_pending), 32'(M_FLAG));
      rst = 1'b1;
      step();
      chk("abort_pending", 32'(wb_pending), 32'd0);
      chk("abort_pc_fetch", 32'(pc_fetch), 32'd1);
      chk("abort_cycles", 32'(cycles), 32'd0);
      rst = 1'b0; run = 1'b0; wb_req = '0; exp_ic = '0;
      for (int i = 0; i < 3; i++) begin
         chk("abort_no_wb_tr", 32'(wb_tr), 32'd0);
         chk("abort_no_pc_wb", 32'(pc_wb_tr), 32'd0);
         step();
      end
      do_instr('0, -1, -1, -1, '0, 1'b0);

      // write-back that is never acknowledged
      do_reset();
      run = 1'b1; wb_req = M_REG; wb_ack = '0;
`ifdef SEQ_WB_TIMEOUT_EN
      repeat (8) step();
      chk("wd_pending_last", 32'(wb_pending), 32'(M_REG));
      chk("wd_not_yet",      32'(wb_timeout), 32'd0);
      step();
      chk("wd_timeout", 32'(wb_timeout), 32'd1);
      chk("wd_halted",  32'(halted),     32'd1);
      chk("wd_pending", 32'(wb_pending), 32'd0);
`else
      repeat (100) step();
      chk("nowd_busy",    32'(busy),       32'd1);
      chk("nowd_pending", 32'(wb_pending), 32'(M_REG));
      chk("nowd_halted",  32'(halted),     32'd0);
      chk("nowd_timeout", 32'(wb_timeout), 32'd0);
`endif
      chk("sb_empty", 32'(sb.size()), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: got no finish expected finish");
      $fatal(1);
   end

endmodule
